// File: rtl/bri_driver.sv
// bri_driver -- H-bridge gate driver for the transmit bridge (clk_dds domain).
//
// Turns the registered 5-bit bridge code from the bridge coder into four
// registered gate commands. Any move between two different conducting
// patterns passes through a programmable dead-time interval. A max-on-time
// watchdog forces the bridge off and latches a fault if POS or NEG is held
// for too long.
//
// Parameters
//   MAX_ON     maximum consecutive clk_dds cycles in POS or NEG before fault
// Ports
//   clk_dds    DDS clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   i          bridge code {turn_delay, quar_delay, phase, half, state_start}
//   dead_time  dead-time length in cycles, sampled on DEAD entry/reload (0 -> 1)
//   q_ah/q_al  A-leg high/low-side gate
//   q_bh/q_bl  B-leg high/low-side gate
//   fault      high while the FSM sits in FAULT
//   pos_cnt    POS entries since state_start last went high, saturating at 255
module bri_driver #(
  parameter logic [15:0] MAX_ON = 16'd4000
) (
  input  logic       clk_dds,
  input  logic       rst,
  input  logic [4:0] i,
  input  logic [7:0] dead_time,
  output logic       q_ah,
  output logic       q_al,
  output logic       q_bh,
  output logic       q_bl,
  output logic       fault,
  output logic [7:0] pos_cnt
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_POS   = 3'd1,
    S_NEG   = 3'd2,
    S_CLAMP = 3'd3,
    S_DEAD  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t      state;
  state_t      pend;
  logic [7:0]  dcnt;
  logic [15:0] on_cnt;

  state_t      tgt;
  state_t      nxt;
  state_t      nxt_pend;
  logic [7:0]  nxt_dcnt;
  logic [15:0] nxt_on_cnt;
  logic [7:0]  d_len;
  logic        drive_state;
  logic        pos_entry;

  // Target requested by the bridge code; only OFF/POS/NEG/CLAMP are produced.
  always_comb begin
    tgt = S_OFF;
    if (!i[0] || i[4] || i[3]) begin
      tgt = S_OFF;
    end else if (!i[1]) begin
      tgt = S_CLAMP;
    end else if (!i[2]) begin
      tgt = S_POS;
    end else begin
      tgt = S_NEG;
    end
  end

  always_comb begin
    d_len       = (dead_time == 8'd0) ? 8'd1 : dead_time;
    drive_state = (state == S_POS) || (state == S_NEG);
  end

  // Next-state logic. Inside POS/NEG the watchdog outranks any target change
  // so an expired on-time can never be dodged by a late command.
  always_comb begin
    nxt      = state;
    nxt_pend = pend;
    nxt_dcnt = dcnt;
    case (state)
      S_OFF: begin
        if (tgt != S_OFF) begin
          nxt = tgt;
        end
      end
      S_POS, S_NEG, S_CLAMP: begin
        if (drive_state && (on_cnt == MAX_ON - 16'd1)) begin
          nxt = S_FAULT;
        end else if (tgt == S_OFF) begin
          nxt = S_OFF;
        end else if (tgt != state) begin
          nxt      = S_DEAD;
          nxt_dcnt = d_len;
          nxt_pend = tgt;
        end
      end
      S_DEAD: begin
        if (tgt == S_OFF) begin
          nxt      = S_OFF;
          nxt_dcnt = '0;
        end else if (tgt != pend) begin
          // A new conducting target restarts the full dead interval.
          nxt_dcnt = d_len;
          nxt_pend = tgt;
        end else if (dcnt <= 8'd1) begin
          nxt      = pend;
          nxt_dcnt = '0;
        end else begin
          nxt_dcnt = dcnt - 8'd1;
        end
      end
      S_FAULT: begin
        if (!i[0]) begin
          nxt = S_OFF;
        end
      end
      default: begin
        nxt = S_OFF;
      end
    endcase
  end

  always_comb begin
    if (nxt != state) begin
      nxt_on_cnt = '0;
    end else if (drive_state) begin
      nxt_on_cnt = on_cnt + 16'd1;
    end else begin
      nxt_on_cnt = on_cnt;
    end
    pos_entry = (nxt == S_POS) && (state != S_POS);
  end

  // Gates and fault are registered straight from the next state so they
  // change on the same edge as the state register.
  always_ff @(posedge clk_dds) begin
    if (rst) begin
      state   <= S_OFF;
      pend    <= S_OFF;
      dcnt    <= '0;
      on_cnt  <= '0;
      q_ah    <= 1'b0;
      q_al    <= 1'b0;
      q_bh    <= 1'b0;
      q_bl    <= 1'b0;
      fault   <= 1'b0;
      pos_cnt <= '0;
    end else begin
      state  <= nxt;
      pend   <= nxt_pend;
      dcnt   <= nxt_dcnt;
      on_cnt <= nxt_on_cnt;

      q_ah  <= (nxt == S_POS);
      q_bl  <= (nxt == S_POS) || (nxt == S_CLAMP);
      q_bh  <= (nxt == S_NEG);
      q_al  <= (nxt == S_NEG) || (nxt == S_CLAMP);
      fault <= (nxt == S_FAULT);

      if (!i[0]) begin
        pos_cnt <= '0;
      end else if (pos_entry && (pos_cnt != 8'hFF)) begin
        pos_cnt <= pos_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bri_driver.sv
// Self-checking bench for bri_driver: a mode-level reference model is stepped
// alongside the DUT and every output is compared after every clock edge,
// with literal expectations on the directed scenarios.
module tb_bri_driver;

  localparam logic [15:0] MAXON = 16'd16;

  // Model mode codes
  localparam int M_OFF = 0, M_POS = 1, M_NEG = 2, M_CLAMP = 3, M_DEAD = 4, M_FAULT = 5;

  logic       clk_dds = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] i = '0;
  logic [7:0] dead_time = '0;
  logic       q_ah, q_al, q_bh, q_bl, fault;
  logic [7:0] pos_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int mode = M_OFF;
  int left = 0;
  int pend = M_OFF;
  int held = 0;
  int pcnt = 0;

  logic [7:0] cur_dt = 8'd4;

  bri_driver #(.MAX_ON(MAXON)) dut (
    .clk_dds  (clk_dds),
    .rst      (rst),
    .i        (i),
    .dead_time(dead_time),
    .q_ah     (q_ah),
    .q_al     (q_al),
    .q_bh     (q_bh),
    .q_bl     (q_bl),
    .fault    (fault),
    .pos_cnt  (pos_cnt)
  );

  always #5 clk_dds = ~clk_dds;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit (got running, required finished)");
    $fatal(1, "timeout");
  end

  function automatic int target_of(input logic [4:0] c);
    if (!c[0] || c[4] || c[3]) return M_OFF;
    if (!c[1]) return M_CLAMP;
    return c[2] ? M_NEG : M_POS;
  endfunction

  function automatic logic [3:0] gates_of(input int m);
    case (m)
      M_POS:   return 4'b1001;
      M_NEG:   return 4'b0110;
      M_CLAMP: return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [4:0] c, input logic [7:0] dt, input logic r);
    int t, d, old;
    if (r) begin
      mode = M_OFF; left = 0; pend = M_OFF; held = 0; pcnt = 0;
      return;
    end
    t   = target_of(c);
    d   = (dt == 0) ? 1 : int'(dt);
    old = mode;
    case (mode)
      M_OFF: if (t != M_OFF) mode = t;
      M_POS, M_NEG, M_CLAMP: begin
        held++;
        if ((mode == M_POS || mode == M_NEG) && held == int'(MAXON)) mode = M_FAULT;
        else if (t == M_OFF) mode = M_OFF;
        else if (t != mode) begin mode = M_DEAD; left = d; pend = t; end
      end
      M_DEAD: begin
        if (t == M_OFF) mode = M_OFF;
        else if (t != pend) begin left = d; pend = t; end
        else begin
          left--;
          if (left == 0) mode = pend;
        end
      end
      M_FAULT: if (!c[0]) mode = M_OFF;
      default: mode = M_OFF;
    endcase
    if (mode != old) held = 0;
    if (!c[0]) pcnt = 0;
    else if (mode == M_POS && old != M_POS && pcnt < 255) pcnt++;
  endtask

  task automatic compare_all();
    check("gates", int'({q_ah, q_al, q_bh, q_bl}), int'(gates_of(mode)));
    check("fault", int'(fault), (mode == M_FAULT) ? 1 : 0);
    check("pos_cnt", int'(pos_cnt), pcnt);
    check("leg_overlap", int'((q_ah & q_al) | (q_bh & q_bl)), 0);
  endtask

  // Apply inputs for one cycle, advance model on the edge, compare 1 ns later.
  task automatic step(input logic [4:0] c, input logic r);
    i = c; dead_time = cur_dt; rst = r;
    @(posedge clk_dds);
    model_edge(c, cur_dt, r);
    #1;
    compare_all();
  endtask

  function automatic logic [3:0] gates_now();
    return {q_ah, q_al, q_bh, q_bl};
  endfunction

  initial begin
    int n;
    logic [4:0] rc;

    // Reset / idle
    cur_dt = 8'd4;
    repeat (3) step(5'b00011, 1'b1);
    check("reset_gates", int'(gates_now()), 0);
    check("reset_fault", int'(fault), 0);
    check("reset_pos_cnt", int'(pos_cnt), 0);
    repeat (2) step(5'b00000, 1'b0);
    check("idle_gates", int'(gates_now()), 0);

    // OFF -> POS -> OFF
    step(5'b00011, 1'b0);
    check("pos_gates", int'(gates_now()), 4'b1001);
    check("pos_cnt_one", int'(pos_cnt), 1);
    step(5'b00000, 1'b0);
    check("off_gates", int'(gates_now()), 0);
    check("off_pos_cnt", int'(pos_cnt), 0);

    // Dead time 4: POS -> NEG
    repeat (3) step(5'b00011, 1'b0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step(5'b00111, 1'b0);
      if (gates_now() == 4'b0000) n++; else break;
    end
    check("dead4_len", n, 4);
    check("dead4_neg", int'(gates_now()), 4'b0110);

    // Dead time 0 behaves as 1: NEG -> POS
    cur_dt = 8'd0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step(5'b00011, 1'b0);
      if (gates_now() == 4'b0000) n++; else break;
    end
    check("dead0_len", n, 1);
    check("dead0_pos", int'(gates_now()), 4'b1001);

    // Reload inside DEAD: 3 dead cycles toward NEG, then switch to CLAMP
    cur_dt = 8'd5;
    step(5'b00000, 1'b0);
    repeat (2) step(5'b00011, 1'b0);
    repeat (3) step(5'b00111, 1'b0);
    n = 3;
    for (int k = 0; k < 20; k++) begin
      step(5'b00001, 1'b0);
      if (gates_now() == 4'b0000) n++; else break;
    end
    check("reload_dead_len", n, 8);
    check("reload_clamp", int'(gates_now()), 4'b0101);

    // Watchdog
    step(5'b00000, 1'b0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step(5'b00011, 1'b0);
      if (fault) break;
      if (gates_now() == 4'b1001) n++;
    end
    check("wd_pos_cycles", n, 16);
    check("wd_fault", int'(fault), 1);
    check("wd_gates", int'(gates_now()), 0);
    step(5'b00111, 1'b0);
    step(5'b00011, 1'b0);
    step(5'b00001, 1'b0);
    check("wd_fault_held", int'(fault), 1);
    step(5'b00000, 1'b0);
    check("wd_fault_clear", int'(fault), 0);
    check("wd_off_gates", int'(gates_now()), 0);

    // pos_cnt saturation via 300 POS/CLAMP alternations
    cur_dt = 8'd0;
    for (int k = 0; k < 300; k++) begin
      repeat (2) step(5'b00011, 1'b0);
      repeat (2) step(5'b00001, 1'b0);
    end
    check("pos_cnt_sat", int'(pos_cnt), 255);

    // Reset in the middle of DEAD
    cur_dt = 8'd10;
    step(5'b00011, 1'b0);
    check("pre_rst_dead", int'(gates_now()), 0);
    step(5'b00011, 1'b1);
    check("mid_rst_gates", int'(gates_now()), 0);
    check("mid_rst_fault", int'(fault), 0);
    check("mid_rst_pos_cnt", int'(pos_cnt), 0);
    step(5'b00011, 1'b0);
    check("post_rst_pos", int'(gates_now()), 4'b1001);
    check("post_rst_pos_cnt", int'(pos_cnt), 1);

    // Randomized run
    rc = 5'b00011;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: rc = 5'b00011;
          1: rc = 5'b00111;
          2: rc = 5'b00001;
          default: rc = 5'($urandom_range(0, 31));
        endcase
      end
      if ($urandom_range(0, 63) == 0) cur_dt = 8'($urandom_range(0, 6));
      step(rc, ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
